// File: rtl/receptor_mdio.sv
// PHY-side MDIO responder: decodes station frames sampled from MDC/MDIO_OUT/MDIO_OE,
// issues register write/read strobes and serialises read data back on MDIO_IN.
module receptor_mdio #(
  parameter logic [4:0] PHY_ADDR    = 5'h00,
  parameter bit         CHECK_PHYAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_HEADER, S_WR_DATA, S_RD_DATA, S_SKIP
  } state_t;

  state_t      r_state;
  logic        r_mdc_q;
  logic [5:0]  r_cnt;
  logic [12:0] r_hdr;
  logic [15:0] r_wr_sh;
  logic [15:0] r_rd_sh;
  logic        r_rd_latch;
  logic        r_mdio_in;
  logic [4:0]  r_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_stb;
  logic        r_rd_stb;
  logic        r_frame_err;

  logic        w_rise;
  logic        w_fall;
  logic [13:0] w_hdr;
  logic [1:0]  w_st;
  logic [1:0]  w_op;
  logic [4:0]  w_phyad;
  logic [4:0]  w_regad;
  logic [5:0]  w_cnt_inc;
  logic [15:0] w_wr_next;

  assign w_rise    = MDC & ~r_mdc_q;
  assign w_fall    = ~MDC & r_mdc_q;
  assign w_hdr     = {r_hdr, MDIO_OUT};
  assign w_st      = w_hdr[13:12];
  assign w_op      = w_hdr[11:10];
  assign w_phyad   = w_hdr[9:5];
  assign w_regad   = w_hdr[4:0];
  assign w_cnt_inc = r_cnt + 6'd1;
  assign w_wr_next = {r_wr_sh[14:0], MDIO_OUT};

  assign MDIO_IN   = r_mdio_in;
  assign ADDR      = r_addr;
  assign WR_DATA   = r_wr_data;
  assign WR_STB    = r_wr_stb;
  assign RD_STB    = r_rd_stb;
  assign FRAME_ERR = r_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_SYNC;
      r_mdc_q     <= 1'b0;
      r_cnt       <= 6'd0;
      r_hdr       <= 13'd0;
      r_wr_sh     <= 16'd0;
      r_rd_sh     <= 16'd0;
      r_rd_latch  <= 1'b0;
      r_mdio_in   <= 1'b0;
      r_addr      <= 5'd0;
      r_wr_data   <= 16'd0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_mdc_q     <= MDC;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      // Register file answers one cycle after RD_STB; capture it then.
      r_rd_latch  <= r_rd_stb;
      if (r_rd_latch)
        r_rd_sh <= RD_DATA;

      // r_cnt is the last sampled bit, so the fall before bit k+1 sees r_cnt==k.
      if (w_fall) begin
        if (r_state == S_RD_DATA && r_cnt >= 6'd16) begin
          r_mdio_in <= r_rd_sh[15];
          r_rd_sh   <= {r_rd_sh[14:0], 1'b0};
        end else begin
          r_mdio_in <= 1'b0;
        end
      end

      if (w_rise) begin
        case (r_state)
          S_SYNC: begin
            if (!MDIO_OE)
              r_state <= S_IDLE;
          end
          S_IDLE: begin
            if (MDIO_OE) begin
              r_hdr   <= w_hdr[12:0];
              r_cnt   <= 6'd1;
              r_state <= S_HEADER;
            end
          end
          S_HEADER: begin
            if (!MDIO_OE) begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_hdr <= w_hdr[12:0];
              r_cnt <= w_cnt_inc;
              if (r_cnt == 6'd13) begin
                if (w_st != 2'b01 || !(w_op == 2'b01 || w_op == 2'b10)) begin
                  r_frame_err <= 1'b1;
                  r_state     <= S_SKIP;
                end else if (CHECK_PHYAD && w_phyad != PHY_ADDR) begin
                  r_state <= S_SKIP;
                end else begin
                  r_addr <= w_regad;
                  if (w_op == 2'b01) begin
                    r_state <= S_WR_DATA;
                  end else begin
                    r_rd_stb <= 1'b1;
                    r_state  <= S_RD_DATA;
                  end
                end
              end
            end
          end
          S_WR_DATA: begin
            if (!MDIO_OE) begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
              if (r_cnt >= 6'd16)
                r_wr_sh <= w_wr_next;
              if (r_cnt == 6'd31) begin
                r_wr_data <= w_wr_next;
                r_wr_stb  <= 1'b1;
                r_state   <= S_IDLE;
              end
            end
          end
          S_RD_DATA, S_SKIP: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == 6'd31)
              r_state <= S_IDLE;
          end
          default: r_state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receptor_mdio.sv
// Directed bench for receptor_mdio: one default instance and one with PHYAD filtering,
// both driven by the same emulated MDIO station.
module tb_receptor_mdio;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data = 16'h46C4;

  logic        d0_mdio_in, d0_wr_stb, d0_rd_stb, d0_frame_err;
  logic [4:0]  d0_addr;
  logic [15:0] d0_wr_data;
  logic        d1_mdio_in, d1_wr_stb, d1_rd_stb, d1_frame_err;
  logic [4:0]  d1_addr;
  logic [15:0] d1_wr_data;

  int checks = 0;
  int errors = 0;
  int n_wr0 = 0, n_rd0 = 0, n_err0 = 0, n_rd1 = 0, n_err1 = 0;
  int s_wr0, s_rd0, s_err0, s_rd1, s_err1;
  logic [31:0] cap0, cap1;
  logic        rd14, err14;

  always #5 clk = ~clk;

  receptor_mdio dut0 (
    .clk(clk), .reset(reset), .MDC(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe),
    .RD_DATA(rd_data), .MDIO_IN(d0_mdio_in), .ADDR(d0_addr), .WR_DATA(d0_wr_data),
    .WR_STB(d0_wr_stb), .RD_STB(d0_rd_stb), .FRAME_ERR(d0_frame_err)
  );

  receptor_mdio #(.PHY_ADDR(5'h18), .CHECK_PHYAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .MDC(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe),
    .RD_DATA(rd_data), .MDIO_IN(d1_mdio_in), .ADDR(d1_addr), .WR_DATA(d1_wr_data),
    .WR_STB(d1_wr_stb), .RD_STB(d1_rd_stb), .FRAME_ERR(d1_frame_err)
  );

  // Pulse counters sample pre-edge values, so each 1-clk strobe counts exactly once.
  always @(posedge clk) begin
    n_wr0  += int'(d0_wr_stb);
    n_rd0  += int'(d0_rd_stb);
    n_err0 += int'(d0_frame_err);
    n_rd1  += int'(d1_rd_stb);
    n_err1 += int'(d1_frame_err);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One MDC period of 4 clk; returns on the negedge just after the rise was processed.
  task automatic send_bit(input logic b, input logic oe);
    @(negedge clk);
    mdc = 1'b0; mdio_out = b; mdio_oe = oe;
    @(negedge clk);
    @(negedge clk);
    mdc = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] f, input int first, input int last, input int oe_last);
    for (int i = first; i <= last; i++) begin
      send_bit(f[32-i], i <= oe_last);
      cap0[32-i] = d0_mdio_in;
      cap1[32-i] = d1_mdio_in;
      if (i == 14) begin
        rd14  = d0_rd_stb;
        err14 = d0_frame_err;
      end
    end
    $display("frame %h bits %0d..%0d oe_last=%0d sent", f, first, last, oe_last);
  endtask

  task automatic snap();
    s_wr0 = n_wr0; s_rd0 = n_rd0; s_err0 = n_err0; s_rd1 = n_rd1; s_err1 = n_err1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; mdc = 1'b0; mdio_out = 1'b0; mdio_oe = 1'b0;
    cap0 = '0; cap1 = '0; rd14 = 1'b0; err14 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mdio_in", 32'(d0_mdio_in), 32'h0);
    chk("rst_addr", 32'(d0_addr), 32'h0);
    chk("rst_wr_data", 32'(d0_wr_data), 32'h0);
    chk("rst_strobes", 32'({d0_wr_stb, d0_rd_stb, d0_frame_err}), 32'h0);
    reset = 1'b0;
    send_bit(1'b0, 1'b0);

    // Plain write, accepted by both instances
    settle(); snap();
    send_bits(32'h5C6AF5B5, 1, 32, 32);
    chk("wr1_stb", 32'(d0_wr_stb), 32'h1);
    chk("wr1_addr", 32'(d0_addr), 32'h1A);
    chk("wr1_data", 32'(d0_wr_data), 32'hF5B5);
    chk("wr1_phy_stb", 32'(d1_wr_stb), 32'h1);
    chk("wr1_phy_addr", 32'(d1_addr), 32'h1A);
    @(negedge clk);
    chk("wr1_stb_low", 32'(d0_wr_stb), 32'h0);
    settle();
    chk("wr1_wr_cnt", 32'(n_wr0 - s_wr0), 32'd1);
    chk("wr1_err_cnt", 32'(n_err0 - s_err0), 32'd0);

    // Read: dut0 answers, dut1 filters PHYAD 1F
    snap();
    send_bits(32'h6FB20000, 1, 32, 14);
    chk("rd_stb_at14", 32'(rd14), 32'h1);
    chk("rd_addr", 32'(d0_addr), 32'h0C);
    chk("rd_mdio_bits", 32'(cap0[16:0]), 32'h046C4);
    chk("rd_phy_mdio", 32'(cap1[16:0]), 32'h0);
    chk("rd_phy_addr", 32'(d1_addr), 32'h1A);
    send_bit(1'b0, 1'b0);
    chk("rd_mdio_after", 32'(d0_mdio_in), 32'h0);
    settle();
    chk("rd_rd_cnt", 32'(n_rd0 - s_rd0), 32'd1);
    chk("rd_err_cnt", 32'(n_err0 - s_err0), 32'd0);
    chk("rd_phy_rd_cnt", 32'(n_rd1 - s_rd1), 32'd0);
    chk("rd_phy_err_cnt", 32'(n_err1 - s_err1), 32'd0);

    // Bad start bits, then a back-to-back valid write
    snap();
    send_bits(32'h9C78402B, 1, 32, 32);
    chk("st_err_at14", 32'(err14), 32'h1);
    settle();
    chk("st_err_cnt", 32'(n_err0 - s_err0), 32'd1);
    chk("st_wr_cnt", 32'(n_wr0 - s_wr0), 32'd0);
    chk("st_rd_cnt", 32'(n_rd0 - s_rd0), 32'd0);
    chk("st_addr", 32'(d0_addr), 32'h0C);
    send_bits(32'h5C6AF5B5, 1, 32, 32);
    chk("st_next_stb", 32'(d0_wr_stb), 32'h1);
    chk("st_next_addr", 32'(d0_addr), 32'h1A);
    chk("st_next_data", 32'(d0_wr_data), 32'hF5B5);

    // Reset in the middle of a write
    settle(); snap();
    send_bits(32'h5C0E1234, 1, 20, 32);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send_bits(32'h5C0E1234, 21, 32, 32);
    settle();
    chk("rstmid_wr_cnt", 32'(n_wr0 - s_wr0), 32'd0);
    chk("rstmid_addr", 32'(d0_addr), 32'h0);
    chk("rstmid_data", 32'(d0_wr_data), 32'h0);
    chk("rstmid_mdio", 32'(d0_mdio_in), 32'h0);
    send_bit(1'b0, 1'b0);
    send_bits(32'h5C0E1234, 1, 32, 32);
    chk("rstmid_next_stb", 32'(d0_wr_stb), 32'h1);
    chk("rstmid_next_addr", 32'(d0_addr), 32'h03);
    chk("rstmid_next_data", 32'(d0_wr_data), 32'h1234);

    // Station releases the line at bit 8
    settle(); snap();
    send_bits(32'h5C6AF5B5, 1, 8, 7);
    settle();
    chk("oe_drop_err_cnt", 32'(n_err0 - s_err0), 32'd1);
    chk("oe_drop_wr_cnt", 32'(n_wr0 - s_wr0), 32'd0);
    chk("oe_drop_addr", 32'(d0_addr), 32'h03);
    send_bits(32'h5C6AF5B5, 1, 32, 32);
    chk("oe_drop_next_stb", 32'(d0_wr_stb), 32'h1);
    chk("oe_drop_next_addr", 32'(d0_addr), 32'h1A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receptor_mdio.md
# receptor_mdio

PHY-side MDIO responder: the far end of the MDIO management generator. Samples the serial frame the station drives on MDC/MDIO_OUT/MDIO_OE and decodes ST/OP/PHYAD/REGAD. Write frames produce a one-cycle register-write strobe. Read frames fetch a 16-bit register value and serialise it back on MDIO_IN during the data phase. Sits between the MDIO bus pins and the PHY register file.

## Interface
- PHY_ADDR, 5'h00, address this PHY answers to.
- CHECK_PHYAD, 0, when 1 frames with PHYAD ≠ PHY_ADDR are ignored; when 0 every PHYAD is accepted.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- MDC  in  1  management clock from station, sampled in clk domain.
- MDIO_OUT  in  1  serial data from station.
- MDIO_OE  in  1  station is driving MDIO_OUT when 1.
- RD_DATA  in  16  register-file read value for ADDR; valid the clk cycle after RD_STB.
- MDIO_IN  out  1  serial read data to station.
- ADDR  out  5  decoded REGAD.
- WR_DATA  out  16  decoded write data.
- WR_STB  out  1  one-cycle write pulse.
- RD_STB  out  1  one-cycle read-request pulse.
- FRAME_ERR  out  1  one-cycle pulse on malformed/aborted frame.

## Operation
- Frame = 32 bits, MSB first. Bits 1-2 ST (must be 01). Bits 3-4 OP (01 write, 10 read). Bits 5-9 PHYAD. Bits 10-14 REGAD. Bits 15-16 TA. Bits 17-32 DATA. No preamble.
- MDC edge detect: mdc_q registered each clk. Rise = MDC & ~mdc_q; fall = ~MDC & mdc_q. All bit sampling happens on the rise cycle.
- States: SYNC, IDLE, HEADER, WR_DATA, RD_DATA, SKIP. A 6-bit counter holds the current bit index.
- SYNC (reset state): leave to IDLE on the first rise with MDIO_OE=0. This prevents decoding the tail of a frame interrupted by reset.
- IDLE: a rise with MDIO_OE=1 captures bit 1 and enters HEADER.
- HEADER: shift bits 2-14. A rise with MDIO_OE=0 → FRAME_ERR pulse, go to IDLE. At bit 14:
  - ST≠01 or OP∉{01,10} → FRAME_ERR pulse, go to SKIP.
  - CHECK_PHYAD=1 and PHYAD mismatch → SKIP, no error.
  - Write → ADDR<=REGAD, go to WR_DATA.
  - Read → ADDR<=REGAD, RD_STB pulse next cycle, go to RD_DATA.
- WR_DATA: ignore bits 15-16 and shift bits 17-32 into WR_DATA. A rise with MDIO_OE=0 → FRAME_ERR, go to IDLE, no WR_STB. After bit 32, WR_STB pulses, then go to IDLE.
- RD_DATA: latch RD_DATA into the output shift register the cycle after RD_STB. Drive MDIO_IN from the falls:
  - the fall preceding bit 16 sets MDIO_IN=0 (TA);
  - the falls preceding bits 17-32 set MDIO_IN to RD_DATA[15] down to [0].
  - MDIO_OE is ignored in this state.
  - After the rise of bit 32, go to IDLE; the next fall returns MDIO_IN to 0.
- SKIP: count to bit 32 with no outputs, then go to IDLE.
- Back-to-back frames: IDLE accepts a new bit 1 on the rise immediately after bit 32, with no gap.

## Timing
- Reset values: MDIO_IN=0, ADDR=0, WR_DATA=0, WR_STB=0, RD_STB=0, FRAME_ERR=0, state SYNC. Reset mid-frame discards all partial data.
- MDC phases: high ≥1 clk and low ≥1 clk, so the minimum MDC period is 2 clk.
- WR_STB: asserted the clk cycle after the bit-32 rise cycle. ADDR and WR_DATA are stable in that cycle and stay stable until the next decode.
- RD_STB: asserted the clk cycle after the bit-14 rise cycle.
- MDIO_IN: updated the clk cycle after each detected fall and held until the next fall.
- Strobes are exactly 1 clk wide. Simultaneous events cannot occur because only one MDC edge exists per clk.
- reset has priority over every edge.

## Test plan
- Write 32'h5C6AF5B5 (station drives MDIO_OE=1 all 32 bits) → ADDR=5'h1A, WR_DATA=16'hF5B5, single WR_STB pulse one clk after bit-32 rise, FRAME_ERR=0.
- Read 32'h6FB2 header (OE=1 bits 1-14, then 0), RD_DATA tied 16'h46C4 → RD_STB once, ADDR=5'h0C; MDIO_IN bits 16-32 = 0,0100_0110_1100_0100; MDIO_IN=0 afterwards.
- Frame 32'h9C78402B (ST=10) → FRAME_ERR pulse at bit 14, no WR_STB/RD_STB, ADDR unchanged; following valid write decodes normally.
- CHECK_PHYAD=1, PHY_ADDR=5'h18: write 32'h5C6AF5B5 → accepted; read 32'h6FB2… (PHYAD 5'h1F) → no RD_STB, MDIO_IN stays 0, FRAME_ERR=0.
- reset asserted at bit 20 of a write for 1 clk, station finishes frame → no WR_STB, all outputs 0; next write (after OE low at a rise) decodes correctly.
- MDIO_OE dropped at bit 8 of a write → FRAME_ERR pulse, return to IDLE, no WR_STB.
